// File: rtl/kb_event_mailbox.sv
// kb_event_mailbox: PS/2 scan-code decoder plus event FIFO behind a
// two-register CPU port.
//   clk, reset   : system clock, asynchronous active-high reset
//   kb_code      : scan-code byte, stable while kb_flag is high
//   kb_flag      : code-valid level from the PS/2 clock domain
//   rd_en, wr_en : single-cycle CPU access strobes
//   addr         : 0 = DATA, 1 = STATUS
//   wdata        : CPU write data (STATUS: bit10 clears OVF, bit11 clears PERR)
//   rdata        : registered read data
//   irq          : high while the FIFO holds at least one event
// Optional feature: define KB_MBOX_BREAK_EN to enqueue break (key release)
// events. Without it, F0 prefixes are still tracked but break events are
// dropped.
module kb_event_mailbox #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  kb_code,
    input  logic        kb_flag,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic        addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] EXT     = 2'd1;
    localparam logic [1:0] BRK     = 2'd2;
    localparam logic [1:0] EXT_BRK = 2'd3;

    // Two synchronizer flops plus one history flop for edge detection.
    logic [2:0] sync_q;
    logic       rise;
    logic [7:0] byte_q;
    logic       byte_vld;

    assign rise = sync_q[1] & ~sync_q[2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= 3'b000;
            byte_q   <= 8'h00;
            byte_vld <= 1'b0;
        end else begin
            sync_q   <= {sync_q[1:0], kb_flag};
            byte_vld <= rise;
            if (rise) byte_q <= kb_code;
        end
    end

    // Decoder
    logic [1:0] state, state_n;
    logic       emit, emit_ext, emit_brk, perr_set;
    logic       is_e0, is_f0;

    assign is_e0 = (byte_q == 8'hE0);
    assign is_f0 = (byte_q == 8'hF0);

    always_comb begin
        state_n  = state;
        emit     = 1'b0;
        emit_ext = 1'b0;
        emit_brk = 1'b0;
        perr_set = 1'b0;
        if (byte_vld) begin
            case (state)
                IDLE: begin
                    if (is_e0)      state_n = EXT;
                    else if (is_f0) state_n = BRK;
                    else            emit    = 1'b1;
                end
                EXT: begin
                    if (is_f0)       state_n = EXT_BRK;
                    else if (!is_e0) begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        state_n  = IDLE;
                    end
                end
                default: begin // BRK, EXT_BRK
                    state_n = IDLE;
                    if (is_e0 || is_f0) perr_set = 1'b1;
                    else begin
                        emit     = 1'b1;
                        emit_ext = (state == EXT_BRK);
                        emit_brk = 1'b1;
                    end
                end
            endcase
        end
    end

    logic       keep;
`ifdef KB_MBOX_BREAK_EN
    assign keep = 1'b1;
`else
    assign keep = ~emit_brk;
`endif

    logic [9:0] ev_q;
    logic       ev_vld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ev_q   <= 10'h000;
            ev_vld <= 1'b0;
        end else begin
            state  <= state_n;
            ev_vld <= emit & keep;
            if (emit) ev_q <= {emit_ext, emit_brk, byte_q};
        end
    end

    // FIFO and CPU port
    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [4:0]    count;
    logic          ovf, perr;
    logic          empty, full, pop, push_ok, wr_ok;

    assign empty   = (count == 5'd0);
    assign full    = (count == 5'(DEPTH));
    assign pop     = rd_en & ~addr & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = ev_vld & (~full | pop);
    assign wr_ok   = wr_en & ~rd_en & addr;
    assign irq     = ~empty;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wp] <= ev_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= 5'd0;
            ovf   <= 1'b0;
            perr  <= 1'b0;
            rdata <= 32'h0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop)     rp <= rp + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
            // Setting wins over a same-cycle clear so no event loss goes unseen.
            if (ev_vld & full & ~pop)         ovf <= 1'b1;
            else if (wr_ok && wdata[10])      ovf <= 1'b0;
            if (perr_set)                     perr <= 1'b1;
            else if (wr_ok && wdata[11])      perr <= 1'b0;
            if (rd_en) begin
                if (addr)
                    rdata <= {20'h0, perr, ovf, full, empty, 3'b000, count};
                else if (!empty)
                    rdata <= {1'b1, 21'h0, mem[rp]};
                else
                    rdata <= 32'h0;
            end
        end
    end
endmodule

// File: tb/tb_kb_event_mailbox.sv
module tb_kb_event_mailbox;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  kb_code = 8'h00;
    logic        kb_flag = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic        addr = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        irq;

    int pass_cnt = 0;
    int total = 0;

    kb_event_mailbox #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .kb_code(kb_code), .kb_flag(kb_flag),
        .rd_en(rd_en), .wr_en(wr_en), .addr(addr), .wdata(wdata),
        .rdata(rdata), .irq(irq)
    );

    always #20 clk = ~clk;

    // Reference model: queue of events plus prefix-seen flags.
    logic [9:0] q[$];
    bit m_ext, m_brk, m_ovf, m_perr;

    function automatic void m_reset();
        q.delete();
        m_ext = 0; m_brk = 0; m_ovf = 0; m_perr = 0;
    endfunction

    function automatic void m_emit(bit e, bit b, logic [7:0] c);
`ifndef KB_MBOX_BREAK_EN
        if (b) return;
`endif
        if (q.size() == DEPTH) m_ovf = 1;
        else q.push_back({e, b, c});
    endfunction

    function automatic void m_byte(logic [7:0] c);
        if (!m_brk) begin
            if (c == 8'hE0) m_ext = 1;
            else if (c == 8'hF0) m_brk = 1;
            else begin m_emit(m_ext, 0, c); m_ext = 0; end
        end else begin
            if (c == 8'hE0 || c == 8'hF0) m_perr = 1;
            else m_emit(m_ext, 1, c);
            m_ext = 0; m_brk = 0;
        end
    endfunction

    function automatic logic [31:0] m_status();
        int n = q.size();
        return {20'h0, m_perr, m_ovf, n == DEPTH, n == 0, 3'b000, 5'(n)};
    endfunction

    function automatic logic [31:0] m_pop();
        if (q.size() == 0) return 32'h0;
        return {1'b1, 21'h0, q.pop_front()};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] c);
        @(negedge clk);
        kb_code = c; kb_flag = 1'b1;
        repeat (6) @(negedge clk);
        kb_flag = 1'b0;
        repeat (4) @(negedge clk);
        m_byte(c);
    endtask

    task automatic rd(input logic a, input string tag);
        logic [31:0] exp;
        @(negedge clk);
        rd_en = 1'b1; addr = a;
        exp = a ? m_status() : m_pop();
        @(negedge clk);
        rd_en = 1'b0;
        chk(tag, rdata, exp);
        chk({tag, "_irq"}, 32'(irq), 32'(q.size() != 0));
    endtask

    task automatic wr(input logic a, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (a && d[10]) m_ovf = 0;
        if (a && d[11]) m_perr = 0;
    endtask

    // Byte arrives while the FIFO is full; DATA read lands on the push clock.
    task automatic send_with_pop(input logic [7:0] c);
        logic [31:0] exp;
        @(negedge clk);
        kb_code = c; kb_flag = 1'b1;
        repeat (4) @(negedge clk);
        rd_en = 1'b1; addr = 1'b0;
        exp = m_pop();
        m_byte(c);
        @(negedge clk);
        rd_en = 1'b0;
        chk("pushpop_data", rdata, exp);
        kb_flag = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        m_reset();
    endtask

    initial begin
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_rdata0", rdata, 32'h0);
        chk("rst_irq0", 32'(irq), 32'h0);
        reset = 1'b0;
        rd(1, "rst_status");
        rd(0, "empty_data");
        rd(1, "empty_status");

        // Two make codes read back in order.
        send(8'h1C); send(8'h23);
        rd(0, "make1");
        chk("make1_const", 32'h8000_001C, {1'b1, 21'h0, 10'h01C}) ;
        rd(0, "make2");
        rd(1, "make_status");
        chk("make_status_const", m_status(), 32'h0000_0100);

        // Extended break.
        send(8'hE0); send(8'hF0); send(8'h74);
`ifdef KB_MBOX_BREAK_EN
        chk("extbrk_irq", 32'(irq), 32'h1);
        rd(0, "extbrk_data");
`else
        chk("extbrk_irq", 32'(irq), 32'h0);
        rd(1, "extbrk_status");
`endif

        // F0 E0 is a protocol error; next code decodes from IDLE.
        send(8'hF0); send(8'hE0);
        rd(1, "perr_status");
        send(8'h1C);
        rd(0, "perr_next");
        wr(1, 32'h0000_0800);
        rd(1, "perr_clear");

        // Overflow.
        for (int i = 0; i <= DEPTH; i++) send(8'h10 + 8'(i));
        rd(1, "ovf_status");
        wr(0, 32'h0000_0C00);
        rd(1, "wr_data_ignored");
        wr(1, 32'h0000_0400);
        rd(1, "ovf_clear");

        // Push and pop together while full.
        send_with_pop(8'h2A);
        rd(1, "pushpop_status");
        for (int i = 0; i < DEPTH; i++) rd(0, "drain");
        rd(0, "drain_empty");

        // Reset mid-prefix.
        send(8'hF0);
        do_reset();
        send(8'h1C);
        rd(0, "rst_prefix");

        // Random bytes interleaved with CPU accesses.
        for (int i = 0; i < 150; i++) begin
            int r;
            logic [7:0] c;
            r = int'($urandom_range(0, 9));
            c = 8'($urandom_range(0, 255));
            if (c == 8'hE0 || c == 8'hF0) c = 8'h5A;
            if (r == 0) c = 8'hE0;
            else if (r <= 2) c = 8'hF0;
            send(c);
            case ($urandom_range(0, 5))
                0: rd(0, "rnd_data");
                1: rd(1, "rnd_status");
                2: wr(1, {20'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'h0});
                default: ;
            endcase
        end
        while (q.size() != 0) rd(0, "rnd_drain");
        rd(1, "rnd_final_status");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
